// File: rtl/gray_code_converter_pipe_if.sv
// Stream bundle for the Gray/binary converter: input beat side plus output beat side.
// Combinational wiring only; no latency.
// in_ready and out_ready carry the backpressure between producer, converter and consumer.
interface gray_code_converter_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
  logic             out_err_nonadj;

  // Producer/consumer view (drives input beats, accepts output beats)
  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_err_nonadj
  );

  // Converter view
  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_err_nonadj
  );
endinterface

// File: rtl/gray_code_converter_pipe.sv
// Pipelined per-beat Gray<->binary converter with a Gray adjacency checker on G2B inputs.
// Latency: STAGES cycles from input acceptance to out_valid; 1 beat/cycle throughput.
// Backpressure: global stall, every stage holds while out_valid && !out_ready; in_ready mirrors that.
module gray_code_converter_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_code_converter_pipe_if.slave cv
);

  // Gray-to-binary is a suffix XOR from the MSB, built as log2 doubling steps:
  // d ^= d>>1, d ^= d>>2, d ^= d>>4 ... Binary-to-Gray is exactly the first step,
  // so B2G beats stop after step 0 and G2B beats run every step.
  localparam int NSTEPS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic             vld;
    logic             mode;   // 0 = G2B, 1 = B2G
    logic [WIDTH-1:0] dat;
    logic             err;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  logic             advance;
  logic             in_fire;
  logic [WIDTH-1:0] prev_word;
  logic             prev_valid;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;
  logic             err_in;

  // Doubling steps are spread evenly across stages; stage s owns every step k
  // with floor(k*STAGES/NSTEPS) == s, so the last step always lands in a real stage.
  function automatic logic [WIDTH-1:0] apply_steps(
    input logic [WIDTH-1:0] d_in,
    input logic             mode,
    input int               stage
  );
    logic [WIDTH-1:0] d;
    d = d_in;
    for (int k = 0; k < NSTEPS; k++) begin
      if ((((k * STAGES) / NSTEPS) == stage) && ((k == 0) || !mode)) begin
        d = d ^ (d >> (1 << k));
      end
    end
    return d;
  endfunction

  assign advance     = !stage_q[STAGES-1].vld || cv.out_ready;
  assign cv.in_ready = advance;
  assign in_fire     = cv.in_valid && advance;

  // Adjacency check: more than one differing bit means diff has a second set bit,
  // i.e. clearing its lowest set bit leaves something behind.
  assign diff      = cv.in_data ^ prev_word;
  assign multi_bit = |(diff & (diff - ONE));
  assign err_in    = cv.in_valid && !cv.in_mode && prev_valid && multi_bit;

  // Next-state for each stage: stage 0 takes the input beat, later stages take their predecessor
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stage_d[s] = '0;
    end
    stage_d[0].vld  = cv.in_valid;
    stage_d[0].mode = cv.in_mode;
    stage_d[0].dat  = apply_steps(cv.in_data, cv.in_mode, 0);
    stage_d[0].err  = err_in;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s].vld  = stage_q[s-1].vld;
      stage_d[s].mode = stage_q[s-1].mode;
      stage_d[s].dat  = apply_steps(stage_q[s-1].dat, stage_q[s-1].mode, s);
      stage_d[s].err  = stage_q[s-1].err;
    end
  end

  // Pipeline registers: shift together on advance, otherwise hold (bubbles stay in place)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  // Checker history: last accepted G2B word; B2G beats leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else if (in_fire && !cv.in_mode) begin
      prev_word  <= cv.in_data;
      prev_valid <= 1'b1;
    end
  end

  assign cv.out_valid      = stage_q[STAGES-1].vld;
  assign cv.out_mode       = stage_q[STAGES-1].mode;
  assign cv.out_data       = stage_q[STAGES-1].dat;
  assign cv.out_err_nonadj = stage_q[STAGES-1].vld && stage_q[STAGES-1].err;

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Scoreboard bench for gray_code_converter_pipe: directed vectors, backpressure, reset flush, random sweep.
// Expected beats come from a plain-arithmetic reference model at acceptance time.
// A separate monitor pops and compares whenever an output transfer is presented.
module tb_gray_code_converter_pipe;
  localparam int W = 8;
  localparam int ST = 2;

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic         err;
    int           acc_edge;
    bit           chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  gray_code_converter_pipe_if #(.WIDTH(W)) ifc ();

  gray_code_converter_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk),
    .rst(rst),
    .cv (ifc.slave)
  );

  always #5 clk = ~clk;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
  logic [W-1:0] m_prev = '0;
  logic         m_prev_vld = 1'b0;

  // Reference model
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Downstream ready generator
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       ifc.out_ready = 1'b1;
        1:       ifc.out_ready = 1'($urandom_range(0, 1));
        default: ifc.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (!ifc.out_valid) begin
          check("idle_err_zero", 32'(ifc.out_err_nonadj), 32'd0);
        end else if (ifc.out_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data %0h with empty scoreboard", ifc.out_data);
          end else begin
            e = sbq.pop_front();
            check("out_data", 32'(ifc.out_data), 32'(e.data));
            check("out_mode", 32'(ifc.out_mode), 32'(e.mode));
            check("out_err",  32'(ifc.out_err_nonadj), 32'(e.err));
            if (e.chk_lat) check("latency_edge", 32'(cyc), 32'(e.acc_edge + ST - 1));
          end
        end
      end
    end
  end

  task automatic send(input logic mode, input logic [W-1:0] data);
    exp_t e;
    int   waited = 0;
    bit   done = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_mode  = mode;
    ifc.in_data  = data;
    while (!done) begin
      #1;
      if (ifc.in_ready) begin
        e.mode     = mode;
        e.data     = mode ? ref_b2g(data) : ref_g2b(data);
        e.err      = 1'b0;
        if (!mode) begin
          e.err      = m_prev_vld && ($countones(data ^ m_prev) > 1);
          m_prev     = data;
          m_prev_vld = 1'b1;
        end
        e.acc_edge = cyc + 1;
        e.chk_lat  = (rdy_mode == 0);
        sbq.push_back(e);
        n_acc++;
        done = 1;
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
      end else if (waited > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", data);
        ifc.in_valid = 1'b0;
        done = 1;
      end else begin
        waited++;
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int n;
    ifc.in_valid = 1'b0;
    ifc.in_mode  = 1'b0;
    ifc.in_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset_out_data",  32'(ifc.out_data), 32'h00);
    check("reset_out_err",   32'(ifc.out_err_nonadj), 32'd0);
    check("reset_in_ready",  32'(ifc.in_ready), 32'd1);

    // G2B basic, ready held high (latency checked in monitor)
    send(1'b0, 8'hFF);
    send(1'b0, 8'h80);
    drain();

    // B2G interleaved with G2B
    send(1'b1, 8'hAA);
    send(1'b0, 8'h81);
    send(1'b1, 8'hFF);
    drain();

    // Adjacency sequence, then again with a B2G beat inserted
    send(1'b0, 8'h00);
    send(1'b0, 8'h01);
    send(1'b0, 8'h03);
    send(1'b0, 8'h03);
    send(1'b0, 8'h00);
    send(1'b0, 8'h01);
    send(1'b0, 8'h03);
    send(1'b1, 8'h55);
    send(1'b0, 8'h00);
    // Gray wraps: all-ones to 0 is flagged, MSB-only to 0 is not
    send(1'b0, 8'hFF);
    send(1'b0, 8'h00);
    send(1'b0, 8'h80);
    send(1'b0, 8'h00);
    drain();

    // Backpressure: ready low, 5 beats offered, only 2 fit
    rdy_mode = 2;
    @(negedge clk);
    target = n_acc + 5;
    fork
      begin
        send(1'b0, 8'h10);
        send(1'b1, 8'h3C);
        send(1'b0, 8'h11);
        send(1'b0, 8'h13);
        send(1'b1, 8'hC3);
      end
    join_none
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      if (ifc.out_valid && sbq.size() > 0) check("stall_head_data", 32'(ifc.out_data), 32'(sbq[0].data));
    end
    check("stall_accepted", 32'(n_acc), 32'(target - 3));
    check("stall_in_ready", 32'(ifc.in_ready), 32'd0);
    rdy_mode = 0;
    n = 0;
    while (n_acc < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_all_accepted", 32'(n_acc), 32'(target));
    drain();

    // Reset with two beats in flight
    rdy_mode = 2;
    @(negedge clk);
    send(1'b0, 8'h00);
    send(1'b0, 8'h01);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("midrst_out_data",  32'(ifc.out_data), 32'h00);
    check("midrst_out_err",   32'(ifc.out_err_nonadj), 32'd0);
    check("midrst_in_ready",  32'(ifc.in_ready), 32'd1);
    sbq.delete();
    m_prev_vld = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(1'b0, 8'hFF);
    drain();

    // Exhaustive round-trip sweep plus random traffic under random ready
    rdy_mode = 1;
    for (int v = 0; v < 256; v++) begin
      send(1'b0, 8'(v));
      send(1'b1, 8'(v));
    end
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom));
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
